// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the sequential binary-to-BCD
//               converter: FSM state encoding, nibble-correction constants and
//               width helpers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // A nibble at or above this value would overflow past 9 after doubling.
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Packed BCD word width for a given digit count.
  function automatic int bcd_width(input int digits);
    return 4 * digits;
  endfunction

  // 10^digits: one past the largest value representable in BCD.
  function automatic longint dec_range(input int digits);
    longint r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bin_to_bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq_if
// Description : Request/result bundle between the datapath and the
//               binary-to-BCD converter.
// Ports       : master drives start, bin_in; receives busy, done, bcd_out.
//               slave  receives start, bin_in; drives busy, done, bcd_out.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );

endinterface : bin_to_bcd_seq_if
`default_nettype wire

// File: rtl/bin_to_bcd_seq_digit_adj.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_adj
// Description : Combinational double-dabble correction cell: a nibble >= 5
//               gets +3 so the following left shift carries correctly into
//               the next decimal digit. No carry out of the nibble.
// Ports       : nib_in  (4) - current BCD digit
//               nib_out (4) - corrected digit, ready to be shifted
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] nib_in,
  output logic [3:0] nib_out
);

  assign nib_out = (nib_in >= ADJ_THRESH) ? (nib_in + ADJ_ADD) : nib_in;

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_seq
// Description : Iterative shift-add-3 binary-to-BCD converter, one bit per
//               clock. The packed BCD result is registered and only updated on
//               the completion edge, so downstream never sees partial digits.
//               With AUTO set, a new conversion launches whenever bin_in
//               differs from the last launched operand.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - slave side: start, bin_in in; busy, done, bcd_out out
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 13,
  parameter int DIGITS = 4,
  parameter int AUTO   = 1
) (
  input  logic           clk,
  input  logic           rst,
  bin_to_bcd_seq_if.slave bus
);

  localparam int              BCD_W    = bcd_width(DIGITS);
  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Reject parameter sets where the largest operand cannot fit in DIGITS.
  if (dec_range(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_digits
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [WIDTH-1:0]   last_bin_q, last_bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic               launch;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .nib_in  (bcd_q[4*g +: 4]),
      .nib_out (bcd_adj[4*g +: 4])
    );
  end

  // An explicit start and an AUTO change on the same cycle are one launch.
  assign launch = bus.start || ((AUTO != 0) && (bus.bin_in != last_bin_q));

  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    last_bin_d = last_bin_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          bcd_d      = '0;
          bin_d      = bus.bin_in;
          last_bin_d = bus.bin_in;
          cnt_d      = CNT_INIT;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Corrected digits and binary operand shift as one register; the
        // binary MSB enters the units digit.
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
        bin_d = {bin_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          bcd_out_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      bcd_q      <= '0;
      bin_q      <= '0;
      last_bin_q <= '0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      last_bin_q <= last_bin_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.busy    = (state_q == ST_SHIFT);
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_out_q;

endmodule : bin_to_bcd_seq
`default_nettype wire
